chase_frame_engine: RTL and testbench
=====================================

Name: chase_frame_engine

Overview:
Frame-synchronous game engine for the chasing-man game; a parametrised successor to the fixed 8-object controller. Once per video frame (iVS rising edge) it moves the player from keypad input and steps each chaser toward the player. It then streams the full object table into the object RAM read by the display path. It also detects capture and manages background selection and level restart.

Parameters:
NUM_OBJ, 8, objects in table; index 0 = player, 1..NUM_OBJ-1 = chasers (min 2, max 16)
X_W, 6, x coordinate width
Y_W, 6, y coordinate width
STEP, 1, player pixels-per-frame step
CHASE_DIV, 2, chasers move once every CHASE_DIV frames (1..15)
ADDR_W, $clog2(NUM_OBJ), RAM address width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
iVS  in  1  vertical sync, asynchronous to clk
iKEY  in  8  keypad levels; [4]=up [5]=down [6]=left [7]=right, others ignored
change  in  1  level change request, asynchronous
oBkg_sel  out  2  background select
oObjRam_addr  out  ADDR_W  object RAM write address
oObjRam_data  out  1+X_W+Y_W  {valid, x, y}
oObjRam_we  out  1  object RAM write strobe
oCaught  out  1  high while the game is frozen after capture

Behaviour:
- Reset (async, reset_n=0): oBkg_sel=0, addr=0, data=0, we=0, oCaught=0, state=IDLE, init_pending=1. Player is set to (2^(X_W-1), 2^(Y_W-1)); chaser k is set to (k*4 mod 2^X_W, 0); frame counter=0.
- iVS and change pass through a 2-flop synchroniser and rising-edge detector. The first oObjRam_we is 3 clk after iVS is first sampled high.
- FSM states: IDLE, MOVE, WRITE, CHECK.
  - IDLE: on a vs edge or pending flag, go to MOVE.
  - MOVE: 1 cycle. Skipped (no motion) if init_pending or oCaught.
    - Player: up subtracts STEP from y; down adds; left/right act on x. Opposing keys both high cancel on that axis.
    - Motion saturates at 0 and 2^W-1; no wrap.
    - Chasers move only when frame_cnt==CHASE_DIV-1. Each steps ±1 on x and ±1 on y toward the player; an axis that is already equal does not move.
    - frame_cnt wraps to 0 at CHASE_DIV-1.
  - WRITE: exactly NUM_OBJ consecutive cycles with we=1, addr=0..NUM_OBJ-1, data={1,x,y} of the post-move positions. Then we=0 and addr=0.
  - CHECK: 1 cycle. If any chaser equals the player position, set oCaught=1 (sticky). Clear init_pending. Return to IDLE.
- A vs edge that arrives outside IDLE sets pending; multiple edges collapse into one pass. No pass is aborted.
- change edge sets chg_pending. It is applied only in IDLE (before starting a pass):
  - oBkg_sel increments mod 4.
  - Positions return to reset values, oCaught=0, frame_cnt=0, init_pending=1.
  - If a vs edge coincides, the change is applied first, then the pass runs as an init pass.
- While oCaught=1, passes still occur and rewrite unchanged positions, so the display stays valid.
- Reset mid-WRITE: we drops immediately (async); the table is rewritten on the next frame.

Optional Feature:
WRAP_EN: when defined, player motion wraps modulo 2^X_W / 2^Y_W; e.g. x=0 with left gives x=2^X_W-STEP. Chaser motion toward the player still uses direct (non-toroidal) distance. When undefined, player motion saturates.

Decomposition:
- Package chase_pkg holds:
  - state enum (IDLE/MOVE/WRITE/CHECK)
  - key bit index constants KEY_UP=4, KEY_DN=5, KEY_LT=6, KEY_RT=7
  - obj_t struct {valid, x, y}
  - the pack function
- One sub-module, edge_sync (2-flop synchroniser + rising-edge pulse), instantiated for iVS and change.

Test Plan:
- Reset release, one iVS pulse → 8 writes, addr 0..7. addr0 data={1,32,32}; addr3 data={1,12,0}. oCaught=0.
- iKEY=8'b00010000 held for 3 frames after init → player y = 32,31,30,29 on successive frames. Then iKEY=8'b00100000 → y increments. iKEY=8'b00110000 → y unchanged.
- Player driven to y=0 and up held → y stays 0. With WRAP_EN defined, the next frame gives y=63.
- CHASE_DIV=2, player stationary at (32,32) → chaser 1 moves from (4,0) to (5,1) after 2 frames, not after 1.
- Chaser driven onto the player position → oCaught=1 after CHECK; the next frames write identical data. A change pulse then gives oBkg_sel=1, oCaught=0, and an init pass with reset positions.
- Two iVS edges inside one WRITE pass → exactly one extra pass follows, for 16 total we cycles.

Source files
------------

// File: rtl/chase_frame_engine_pkg.sv
// Shared types for the chase frame engine: FSM states, keypad bit positions, object entry packing.
// Optional build macro used by the engine: WRAP_EN (toroidal player motion).
package chase_pkg;

    typedef enum logic [1:0] {IDLE, MOVE, WRITE, CHECK} state_t;

    localparam int KEY_UP = 4;
    localparam int KEY_DN = 5;
    localparam int KEY_LT = 6;
    localparam int KEY_RT = 7;

    // Widest coordinate supported; actual widths are narrowed by the caller.
    localparam int MAX_W = 16;

    typedef struct packed {
        logic             valid;
        logic [MAX_W-1:0] x;
        logic [MAX_W-1:0] y;
    } obj_t;

    // Right-justified {valid, x, y} for the given coordinate widths.
    function automatic logic [2*MAX_W:0] pack(input obj_t o, input int xw, input int yw);
        logic [2*MAX_W:0] r;
        r = ((2*MAX_W+1)'(o.valid) << (xw + yw))
          | ((2*MAX_W+1)'(o.x) << yw)
          | (2*MAX_W+1)'(o.y);
        return r;
    endfunction

endpackage

// File: rtl/chase_frame_engine_edge_sync.sv
// Two-flop synchroniser for an asynchronous level plus a single-cycle rising-edge pulse.
// Latency: pulse is high in the cycle after the second flop first captures the level.
module edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic pulse
);

    logic [2:0] sh;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sh <= '0;
        else          sh <= {sh[1:0], din};
    end

    assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/chase_frame_engine.sv
// Per-frame chase game engine: moves player/chasers, streams the object table, detects capture.
// First RAM write 3 clk after iVS is first sampled high; WRAP_EN selects wrapping player motion.
module chase_frame_engine
    import chase_pkg::*;
#(
    parameter int NUM_OBJ   = 8,
    parameter int X_W       = 6,
    parameter int Y_W       = 6,
    parameter int STEP      = 1,
    parameter int CHASE_DIV = 2,
    parameter int ADDR_W    = $clog2(NUM_OBJ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 iVS,
    input  logic [7:0]           iKEY,
    input  logic                 change,
    output logic [1:0]           oBkg_sel,
    output logic [ADDR_W-1:0]    oObjRam_addr,
    output logic [X_W+Y_W:0]     oObjRam_data,
    output logic                 oObjRam_we,
    output logic                 oCaught
);

    localparam int DW = 1 + X_W + Y_W;
    localparam logic [X_W-1:0] XMAX = '1;
    localparam logic [Y_W-1:0] YMAX = '1;

    state_t         state;
    logic           vsEdge, chgEdge, vsPend, chgPend, initPend;
    logic [3:0]     frameCnt;
    logic [X_W-1:0] xPos [NUM_OBJ];
    logic [Y_W-1:0] yPos [NUM_OBJ];
    logic [X_W-1:0] outX [NUM_OBJ];
    logic [Y_W-1:0] outY [NUM_OBJ];
    logic           moveNow, chaseNow, hit;
    logic           unusedKeys;

    assign unusedKeys = ^iKEY[3:0];

    edge_sync uVsSync  (.clk(clk), .reset_n(reset_n), .din(iVS),    .pulse(vsEdge));
    edge_sync uChgSync (.clk(clk), .reset_n(reset_n), .din(change), .pulse(chgEdge));

    function automatic logic [X_W-1:0] resetX(input int k);
        return (k == 0) ? X_W'(2 ** (X_W - 1)) : X_W'((k * 4) % (2 ** X_W));
    endfunction

    function automatic logic [Y_W-1:0] resetY(input int k);
        return (k == 0) ? Y_W'(2 ** (Y_W - 1)) : '0;
    endfunction

    function automatic logic [X_W-1:0] stepX(input logic [X_W-1:0] v, input logic inc, input logic dec);
`ifdef WRAP_EN
        if (inc && !dec) return v + X_W'(STEP);
        if (dec && !inc) return v - X_W'(STEP);
`else
        if (inc && !dec) return (v > XMAX - X_W'(STEP)) ? XMAX : v + X_W'(STEP);
        if (dec && !inc) return (v < X_W'(STEP)) ? '0 : v - X_W'(STEP);
`endif
        return v;
    endfunction

    function automatic logic [Y_W-1:0] stepY(input logic [Y_W-1:0] v, input logic inc, input logic dec);
`ifdef WRAP_EN
        if (inc && !dec) return v + Y_W'(STEP);
        if (dec && !inc) return v - Y_W'(STEP);
`else
        if (inc && !dec) return (v > YMAX - Y_W'(STEP)) ? YMAX : v + Y_W'(STEP);
        if (dec && !inc) return (v < Y_W'(STEP)) ? '0 : v - Y_W'(STEP);
`endif
        return v;
    endfunction

    // Chasers always close in along the direct (non-wrapping) distance.
    function automatic logic [MAX_W-1:0] toward(input logic [MAX_W-1:0] c, input logic [MAX_W-1:0] p);
        if (c < p) return c + 1'b1;
        if (c > p) return c - 1'b1;
        return c;
    endfunction

    function automatic logic [DW-1:0] entry(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        obj_t o;
        o.valid = 1'b1;
        o.x     = MAX_W'(x);
        o.y     = MAX_W'(y);
        return DW'(pack(o, X_W, Y_W));
    endfunction

    assign moveNow  = (state == MOVE) && !initPend && !oCaught;
    assign chaseNow = (frameCnt == 4'(CHASE_DIV - 1));

    // Post-move positions; chasers aim at where the player ends up this frame.
    always_comb begin
        outX[0] = xPos[0];
        outY[0] = yPos[0];
        if (moveNow) begin
            outX[0] = stepX(xPos[0], iKEY[KEY_RT], iKEY[KEY_LT]);
            outY[0] = stepY(yPos[0], iKEY[KEY_DN], iKEY[KEY_UP]);
        end
        hit = 1'b0;
        for (int k = 1; k < NUM_OBJ; k++) begin
            outX[k] = xPos[k];
            outY[k] = yPos[k];
            if (moveNow && chaseNow) begin
                outX[k] = X_W'(toward(MAX_W'(xPos[k]), MAX_W'(outX[0])));
                outY[k] = Y_W'(toward(MAX_W'(yPos[k]), MAX_W'(outY[0])));
            end
            if (xPos[k] == xPos[0] && yPos[k] == yPos[0]) hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            oBkg_sel     <= '0;
            oObjRam_addr <= '0;
            oObjRam_data <= '0;
            oObjRam_we   <= 1'b0;
            oCaught      <= 1'b0;
            vsPend       <= 1'b0;
            chgPend      <= 1'b0;
            initPend     <= 1'b1;
            frameCnt     <= '0;
            for (int k = 0; k < NUM_OBJ; k++) begin
                xPos[k] <= resetX(k);
                yPos[k] <= resetY(k);
            end
        end else begin
            if (state != IDLE) begin
                if (vsEdge)  vsPend  <= 1'b1;
                if (chgEdge) chgPend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // A level change is applied before any pass starts, so that pass is an init pass.
                    if (chgPend || chgEdge) begin
                        chgPend  <= 1'b0;
                        oBkg_sel <= oBkg_sel + 2'd1;
                        oCaught  <= 1'b0;
                        frameCnt <= '0;
                        initPend <= 1'b1;
                        for (int k = 0; k < NUM_OBJ; k++) begin
                            xPos[k] <= resetX(k);
                            yPos[k] <= resetY(k);
                        end
                    end
                    if (vsPend || vsEdge) begin
                        vsPend <= 1'b0;
                        state  <= MOVE;
                    end
                end
                MOVE: begin
                    if (moveNow) frameCnt <= chaseNow ? '0 : frameCnt + 4'd1;
                    for (int k = 0; k < NUM_OBJ; k++) begin
                        xPos[k] <= outX[k];
                        yPos[k] <= outY[k];
                    end
                    oObjRam_we   <= 1'b1;
                    oObjRam_addr <= '0;
                    oObjRam_data <= entry(outX[0], outY[0]);
                    state        <= WRITE;
                end
                WRITE: begin
                    if (oObjRam_addr == ADDR_W'(NUM_OBJ - 1)) begin
                        oObjRam_we   <= 1'b0;
                        oObjRam_addr <= '0;
                        oObjRam_data <= '0;
                        state        <= CHECK;
                    end else begin
                        oObjRam_addr <= oObjRam_addr + 1'b1;
                        oObjRam_data <= entry(xPos[ADDR_W'(oObjRam_addr + 1'b1)],
                                              yPos[ADDR_W'(oObjRam_addr + 1'b1)]);
                    end
                end
                CHECK: begin
                    if (hit) oCaught <= 1'b1;
                    initPend <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chase_frame_engine.sv
// Directed bench for chase_frame_engine with a frame-level reference model and write scoreboard.
module tb_chase_frame_engine;

    localparam int N    = 8;
    localparam int XW   = 6;
    localparam int YW   = 6;
    localparam int STEP = 1;
    localparam int DIV  = 2;
    localparam int AW   = 3;
    localparam int DW   = 1 + XW + YW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          iVS = 1'b0;
    logic          change = 1'b0;
    logic [7:0]    iKEY = '0;
    logic [1:0]    oBkg_sel;
    logic [AW-1:0] oObjRam_addr;
    logic [DW-1:0] oObjRam_data;
    logic          oObjRam_we;
    logic          oCaught;

    chase_frame_engine #(
        .NUM_OBJ(N), .X_W(XW), .Y_W(YW), .STEP(STEP), .CHASE_DIV(DIV), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .iVS(iVS), .iKEY(iKEY), .change(change),
        .oBkg_sel(oBkg_sel), .oObjRam_addr(oObjRam_addr), .oObjRam_data(oObjRam_data),
        .oObjRam_we(oObjRam_we), .oCaught(oCaught)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int weCount = 0;
    logic [AW+DW-1:0] expQ[$];
    logic [DW-1:0]    seen [N];

    int mx [N];
    int my [N];
    int mfc;
    int mBkg;
    bit mInit;
    bit mCaught;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int limitW(input int v, input int w);
`ifdef WRAP_EN
        return (v + (1 << w)) % (1 << w);
`else
        if (v < 0) return 0;
        if (v > (1 << w) - 1) return (1 << w) - 1;
        return v;
`endif
    endfunction

    function automatic int sgn(input int d);
        return int'(d > 0) - int'(d < 0);
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < N; i++) begin
            mx[i] = (i == 0) ? (1 << (XW - 1)) : (i * 4) % (1 << XW);
            my[i] = (i == 0) ? (1 << (YW - 1)) : 0;
        end
        mfc = 0;
        mInit = 1'b1;
        mCaught = 1'b0;
    endfunction

    // One full frame pass: move (unless init/frozen), emit table, then capture test.
    function automatic void modelPass(input logic [7:0] k);
        if (!mInit && !mCaught) begin
            mx[0] = limitW(mx[0] + STEP * (int'(k[7]) - int'(k[6])), XW);
            my[0] = limitW(my[0] + STEP * (int'(k[5]) - int'(k[4])), YW);
            if (mfc == DIV - 1) begin
                for (int i = 1; i < N; i++) begin
                    mx[i] = mx[i] + sgn(mx[0] - mx[i]);
                    my[i] = my[i] + sgn(my[0] - my[i]);
                end
            end
            mfc = (mfc + 1) % DIV;
        end
        for (int i = 0; i < N; i++)
            expQ.push_back({AW'(i), 1'b1, XW'(mx[i]), YW'(my[i])});
        for (int i = 1; i < N; i++)
            if (mx[i] == mx[0] && my[i] == my[0]) mCaught = 1'b1;
        mInit = 1'b0;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (oObjRam_we) begin
                logic [AW+DW-1:0] e;
                weCount++;
                seen[oObjRam_addr] = oObjRam_data;
                tests++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: addr %0d data %0h with empty scoreboard",
                             oObjRam_addr, oObjRam_data);
                end else begin
                    e = expQ.pop_front();
                    if ({oObjRam_addr, oObjRam_data} !== e) begin
                        fails++;
                        $display("FAIL obj_write: got addr %0d data %0h expected addr %0d data %0h",
                                 oObjRam_addr, oObjRam_data, e[AW+DW-1:DW], e[DW-1:0]);
                    end
                end
            end else begin
                tests++;
                if (oObjRam_addr !== '0) begin
                    fails++;
                    $display("FAIL idle_addr: got %0d expected 0", oObjRam_addr);
                end
            end
        end
    end

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d writes outstanding, expected 0", expQ.size());
            expQ.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] k);
        int n;
        iKEY = k;
        modelPass(k);
        @(negedge clk);
        iVS = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!oObjRam_we && n < 20);
        check("vs_to_we_latency", n - 1, 3);
        @(negedge clk);
        iVS = 1'b0;
        waitDrain();
        check("caught", int'(oCaught), int'(mCaught));
        check("bkg_sel", int'(oBkg_sel), mBkg);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        modelReset();
        mBkg = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_bkg", int'(oBkg_sel), 0);
        check("reset_addr", int'(oObjRam_addr), 0);
        check("reset_data", int'(oObjRam_data), 0);
        check("reset_we", int'(oObjRam_we), 0);
        check("reset_caught", int'(oCaught), 0);
        @(negedge clk);
        reset_n = 1'b1;

        frame(8'h00);
        check("init_player_entry", int'(seen[0]), 'h1820);
        check("init_chaser3_entry", int'(seen[3]), 'h1300);

        frame(8'h10);
        check("chaser1_after_1_frame", int'(seen[1]), 'h1100);
        frame(8'h10);
        check("chaser1_after_2_frames", int'(seen[1]), 'h1141);
        frame(8'h10);
        check("player_y29", int'(seen[0]), 'h181D);
        frame(8'h20);
        check("player_down_y30", int'(seen[0]), 'h181E);
        frame(8'h30);
        check("player_up_down_cancel", int'(seen[0]), 'h181E);

        repeat (32) frame(8'h90);
        frame(8'h10);
`ifndef WRAP_EN
        check("player_saturated_63_0", int'(seen[0]), 'h1FC0);
`endif

        n = 0;
        while (!mCaught && n < 200) begin
            frame(8'h00);
            n++;
        end
        check("capture_reached", int'(oCaught), 1);
        frame(8'h40);
`ifndef WRAP_EN
        check("frozen_player_entry", int'(seen[0]), 'h1FC0);
`endif

        @(negedge clk);
        change = 1'b1;
        @(negedge clk);
        change = 1'b0;
        modelReset();
        mBkg = (mBkg + 1) % 4;
        repeat (6) @(posedge clk);
        #1;
        check("bkg_after_change", int'(oBkg_sel), 1);
        check("caught_cleared", int'(oCaught), 0);
        frame(8'h00);
        check("restart_player_entry", int'(seen[0]), 'h1820);
        check("restart_chaser3_entry", int'(seen[3]), 'h1300);

        weCount = 0;
        iKEY = 8'h00;
        modelPass(8'h00);
        modelPass(8'h00);
        @(negedge clk);
        iVS = 1'b1;
        repeat (4) @(negedge clk);
        iVS = 1'b0;
        @(negedge clk);
        iVS = 1'b1;
        @(negedge clk);
        iVS = 1'b0;
        repeat (2) @(negedge clk);
        iVS = 1'b1;
        @(negedge clk);
        iVS = 1'b0;
        waitDrain();
        repeat (20) @(posedge clk);
        #1;
        check("collapsed_vs_we_cycles", weCount, 16);
        check("collapsed_vs_queue_empty", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
